m_muldiv_unit: RTL
==================

Name: m_muldiv_unit

Overview:
Iterative multiply/divide unit for the CPU's M-extension ops.
- Sits between the register file read ports (src_a/src_b come from out0/out1) and the register file write port (result/rd_out/we_out drive data/a2/we).
- Operands are latched on start. The unit computes over 32 clock cycles, one bit per cycle, then presents a registered result with a one-cycle write strobe.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN
REG_ADDR_W, 5, destination register address width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  3  000 MUL, 001 MULHU, 010 DIVU, 011 REMU, 100 MUL, 101 MULH, 110 DIV, 111 REM
src_a  input  XLEN  multiplicand/dividend (register file out0)
src_b  input  XLEN  multiplier/divisor (register file out1)
rd_in  input  REG_ADDR_W  destination register of the request
busy  output  1  high from acceptance until the done cycle ends
done  output  1  one-cycle pulse, result valid
result  output  XLEN  computed value; holds until the next accepted start
rd_out  output  REG_ADDR_W  latched rd_in, to register file a2
we_out  output  1  done AND (rd_out != 0), to register file we

Behaviour:
- Reset (synchronous, highest priority) forces:
  - state IDLE; busy=0, done=0, we_out=0
  - result=0, rd_out=0, internal counter=0
- Reset mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE -> CALC: on edge E0 with start=1. Latch op, src_a, src_b, rd_in; counter=XLEN-1; busy=1.
  - CALC: one iteration per edge, counter decrements. At the edge where counter==0, go to DONE and register the result.
  - DONE: done=1, busy=1 for exactly one cycle, then IDLE.
- Timing:
  - With start sampled at E0, iterations occur at E1..E32.
  - done is high between E32 and E33; busy falls at E33.
  - A new start may be accepted at E33.
- start with busy=1 (CALC or DONE) is ignored and has no side effects.
- Operand inputs may change freely after E0.
- Multiply: shift-add over a 2*XLEN product.
  - MUL returns the low XLEN bits.
  - MULHU/MULH return the high XLEN bits.
- Divide: restoring shift-subtract; quotient for DIV/DIVU, remainder for REM/REMU.
- Divide by zero (no trap):
  - quotient = all ones
  - remainder = dividend
- Signed ops (macro enabled):
  - Operate on magnitudes, then fix sign.
  - Quotient sign = sign_a XOR sign_b.
  - Remainder takes the sign of the dividend.
  - Signed divide by zero: quotient = -1, remainder = dividend.
  - Overflow 0x80000000 / -1: quotient 0x80000000, remainder 0.
- MUL (op 000/100) low result is sign-agnostic.
- rd_in = 0: the operation runs normally and result is updated, but we_out stays 0.
- result and rd_out change only at the DONE transition (or reset); they are stable in IDLE.

Optional Feature:
- Macro M_MULDIV_SIGNED_EN.
- Defined: op[2]=1 selects the signed variants (101 MULH signed x signed, 110 DIV, 111 REM), with the sign handling above.
- Undefined: op[2] is ignored and the signed variants execute as their unsigned counterparts (101->MULHU, 110->DIVU, 111->REMU). No sign-correction logic is synthesised.
- Latency is identical in both builds.

Test Plan:
1. Reset, then start op=000 src_a=6 src_b=7 rd_in=5 at E0 -> busy=1 after E0; done=1, we_out=1, result=42, rd_out=5 only between E32 and E33; busy=0 after E33.
2. op=001 src_a=src_b=0xFFFFFFFF -> result=0xFFFFFFFE; then op=010 420/69 -> result=6; op=011 420/69 -> result=6.
3. op=010 69/0 -> result=0xFFFFFFFF; op=011 69/0 -> result=69; done still after exactly 32 iterations.
4. Pulse start with op=000 src_a=3 src_b=3 at E5 during an operation started at E0 -> ignored; only one done pulse, at E32..E33, carrying the first op's result. Separately, assert reset at E10 -> busy=0, result=0, no done.
5. rd_in=0, op=000 src_a=2 src_b=2 -> done=1, result=4, we_out=0.
6. With M_MULDIV_SIGNED_EN:
   - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0
   - MULH -1 x -1 -> 0x00000000
   Without the macro, op=110 -7/2 -> 0x7FFFFFFC.

Source files
------------

// File: rtl/m_muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit for M-extension ops.
// Define M_MULDIV_SIGNED_EN to enable the signed variants (MULH, DIV, REM).
module m_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [XLEN-1:0]       src_a,
    input  logic [XLEN-1:0]       src_b,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  we_out
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            kind_q, kind_d;
    logic [XLEN-1:0]       hi_q, hi_d;
    logic [XLEN-1:0]       lo_q, lo_d;
    logic [XLEN-1:0]       b_q, b_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;
    logic [XLEN-1:0]       result_q, result_d;

    logic [XLEN-1:0]       mag_a, mag_b;
    logic [XLEN:0]         mul_sum, div_tmp, div_diff;
    logic                  div_ge;
    logic [XLEN-1:0]       step_hi, step_lo;
    logic [2*XLEN-1:0]     prod, prod_fix;
    logic [XLEN-1:0]       div_val, final_res;

`ifdef M_MULDIV_SIGNED_EN
    logic is_signed_op, sign_a, sign_b, start_neg;
    logic neg_q, neg_d;

    // Signed ops run on magnitudes; neg records whether the result needs negating.
    // A signed divide by zero keeps the all-ones quotient, so it is never negated.
    always_comb begin
        is_signed_op = op[2] & (op[1:0] != 2'b00);
        sign_a       = is_signed_op & src_a[XLEN-1];
        sign_b       = is_signed_op & src_b[XLEN-1];
        mag_a        = sign_a ? -src_a : src_a;
        mag_b        = sign_b ? -src_b : src_b;
        case (op[1:0])
            2'b01:   start_neg = sign_a ^ sign_b;
            2'b10:   start_neg = (sign_a ^ sign_b) & (src_b != '0);
            2'b11:   start_neg = sign_a;
            default: start_neg = 1'b0;
        endcase
    end
`else
    logic unused_op_sign;

    assign unused_op_sign = op[2];
    assign mag_a          = src_a;
    assign mag_b          = src_b;
`endif

    // hi/lo hold {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_tmp  = {hi_q, lo_q[XLEN-1]};
        div_diff = div_tmp - {1'b0, b_q};
        div_ge   = ~div_diff[XLEN];
        if (kind_q[1]) begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = prod;
        div_val  = kind_q[0] ? step_hi : step_lo;
`ifdef M_MULDIV_SIGNED_EN
        if (neg_q) begin
            prod_fix = -prod;
            div_val  = -(kind_q[0] ? step_hi : step_lo);
        end
`endif
        case (kind_q)
            2'b00:   final_res = prod_fix[XLEN-1:0];
            2'b01:   final_res = prod_fix[2*XLEN-1:XLEN];
            default: final_res = div_val;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        result_d = result_q;
`ifdef M_MULDIV_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = CNT_W'(XLEN - 1);
                    kind_d  = op[1:0];
                    hi_d    = '0;
                    lo_d    = mag_a;
                    b_d     = mag_b;
                    rd_d    = rd_in;
`ifdef M_MULDIV_SIGNED_EN
                    neg_d   = start_neg;
`endif
                end
            end
            S_CALC: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                    rd_out_d = rd_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            kind_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            result_q <= '0;
`ifdef M_MULDIV_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
`ifdef M_MULDIV_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;
    assign we_out = done & (rd_out_q != '0);

endmodule
